// File: rtl/tile_gemm_controller.sv
// Tile-level sequencer for a weight-stationary systolic GEMM array.
// For every N tile: load weights, then for every M tile stream K inputs,
// flush the array pipeline and drain ARRAY_COL output beats.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   ap_start, ap_abort            job start (level, IDLE only) / abort
//   cfg_k_dim/m_tiles/n_tiles     job shape, latched at start
//   drain_ready                   output buffer accepts a beat this cycle
//   ap_done, ap_idle, cfg_err     job status
//   state_dbg                     current state encoding
//   ctrl_*                        array control enables (state decodes)
//   tile_m_idx, tile_n_idx        current tile indices
//   phase_cnt                     cycle/beat counter within current state
module tile_gemm_controller #(
    parameter int unsigned ARRAY_ROW = 8,
    parameter int unsigned ARRAY_COL = 8,
    parameter int unsigned PIPE_LAT  = 15,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ap_start,
    input  logic             ap_abort,
    input  logic [CNT_W-1:0] cfg_k_dim,
    input  logic [CNT_W-1:0] cfg_m_tiles,
    input  logic [CNT_W-1:0] cfg_n_tiles,
    input  logic             drain_ready,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             cfg_err,
    output logic [2:0]       state_dbg,
    output logic             ctrl_weight_load_en,
    output logic             ctrl_input_stream_en,
    output logic             ctrl_acc_clear,
    output logic             ctrl_flush_en,
    output logic             ctrl_drain_en,
    output logic [CNT_W-1:0] tile_m_idx,
    output logic [CNT_W-1:0] tile_n_idx,
    output logic [CNT_W-1:0] phase_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(ARRAY_ROW - 1);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(ARRAY_COL - 1);
    localparam logic [CNT_W-1:0] PIPE_LAST = CNT_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] phase_nx, m_nx, n_nx;
    logic [CNT_W-1:0] k_lat, m_lat, n_lat;
    logic [CNT_W-1:0] k_lat_nx, m_lat_nx, n_lat_nx;
    logic             err_nx;

    assign state_dbg = state;

    // Next-state, counter and latched-config logic
    always_comb begin
        state_nx = state;
        phase_nx = phase_cnt;
        m_nx     = tile_m_idx;
        n_nx     = tile_n_idx;
        k_lat_nx = k_lat;
        m_lat_nx = m_lat;
        n_lat_nx = n_lat;
        err_nx   = cfg_err;

        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    k_lat_nx = cfg_k_dim;
                    m_lat_nx = cfg_m_tiles;
                    n_lat_nx = cfg_n_tiles;
                    phase_nx = '0;
                    m_nx     = '0;
                    n_nx     = '0;
                    if ((cfg_k_dim == '0) || (cfg_m_tiles == '0) || (cfg_n_tiles == '0)) begin
                        state_nx = S_DONE;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx = S_LOAD_W;
                        err_nx   = 1'b0;
                    end
                end
            end
            S_LOAD_W: begin
                if (phase_cnt == ROW_LAST) begin
                    state_nx = S_COMPUTE;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase_cnt + ONE;
                end
            end
            S_COMPUTE: begin
                if (phase_cnt == (k_lat - ONE)) begin
                    state_nx = S_FLUSH;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase_cnt + ONE;
                end
            end
            S_FLUSH: begin
                if (phase_cnt == PIPE_LAST) begin
                    state_nx = S_DRAIN;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase_cnt + ONE;
                end
            end
            S_DRAIN: begin
                // Only accepted beats advance; stall indefinitely otherwise
                if (drain_ready) begin
                    if (phase_cnt == COL_LAST) begin
                        phase_nx = '0;
                        if (tile_m_idx < (m_lat - ONE)) begin
                            m_nx     = tile_m_idx + ONE;
                            state_nx = S_COMPUTE;
                        end else if (tile_n_idx < (n_lat - ONE)) begin
                            m_nx     = '0;
                            n_nx     = tile_n_idx + ONE;
                            state_nx = S_LOAD_W;
                        end else begin
                            state_nx = S_DONE;
                        end
                    end else begin
                        phase_nx = phase_cnt + ONE;
                    end
                end
            end
            S_DONE: begin
                if (!ap_start) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                phase_nx = '0;
            end
        endcase

        // Abort overrides every transition of an active job
        if (ap_abort && (state != S_IDLE) && (state != S_DONE)) begin
            state_nx = S_IDLE;
            phase_nx = '0;
        end
    end

    // State register; outputs registered as decodes of the next state so
    // they line up with the state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            phase_cnt            <= '0;
            tile_m_idx           <= '0;
            tile_n_idx           <= '0;
            k_lat                <= '0;
            m_lat                <= '0;
            n_lat                <= '0;
            cfg_err              <= 1'b0;
            ap_done              <= 1'b0;
            ap_idle              <= 1'b1;
            ctrl_weight_load_en  <= 1'b0;
            ctrl_input_stream_en <= 1'b0;
            ctrl_acc_clear       <= 1'b0;
            ctrl_flush_en        <= 1'b0;
            ctrl_drain_en        <= 1'b0;
        end else begin
            state                <= state_nx;
            phase_cnt            <= phase_nx;
            tile_m_idx           <= m_nx;
            tile_n_idx           <= n_nx;
            k_lat                <= k_lat_nx;
            m_lat                <= m_lat_nx;
            n_lat                <= n_lat_nx;
            cfg_err              <= err_nx;
            ap_done              <= (state_nx == S_DONE);
            ap_idle              <= (state_nx == S_IDLE);
            ctrl_weight_load_en  <= (state_nx == S_LOAD_W);
            ctrl_input_stream_en <= (state_nx == S_COMPUTE);
            ctrl_acc_clear       <= (state_nx == S_COMPUTE) && (phase_nx == '0);
            ctrl_flush_en        <= (state_nx == S_FLUSH);
            ctrl_drain_en        <= (state_nx == S_DRAIN);
        end
    end

endmodule

// File: tb/tb_tile_gemm_controller.sv
// Randomized self-checking bench for tile_gemm_controller with a
// loop-based reference model of the tile schedule.
module tb_tile_gemm_controller;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int PL  = 15;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ap_start, ap_abort, drain_ready;
    logic [W-1:0] cfg_k_dim, cfg_m_tiles, cfg_n_tiles;
    logic         ap_done, ap_idle, cfg_err;
    logic [2:0]   state_dbg;
    logic         ctrl_weight_load_en, ctrl_input_stream_en, ctrl_acc_clear;
    logic         ctrl_flush_en, ctrl_drain_en;
    logic [W-1:0] tile_m_idx, tile_n_idx, phase_cnt;

    always #5 clk = ~clk;

    tile_gemm_controller #(
        .ARRAY_ROW(ROW), .ARRAY_COL(COL), .PIPE_LAT(PL), .CNT_W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_abort(ap_abort),
        .cfg_k_dim(cfg_k_dim), .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles),
        .drain_ready(drain_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .cfg_err(cfg_err), .state_dbg(state_dbg),
        .ctrl_weight_load_en(ctrl_weight_load_en),
        .ctrl_input_stream_en(ctrl_input_stream_en),
        .ctrl_acc_clear(ctrl_acc_clear), .ctrl_flush_en(ctrl_flush_en),
        .ctrl_drain_en(ctrl_drain_en), .tile_m_idx(tile_m_idx),
        .tile_n_idx(tile_n_idx), .phase_cnt(phase_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] st;
        int         ph;
        int         m;
        int         n;
        bit         rdy;
    } rec_t;

    rec_t exp_q[$];
    int   visit_q[$];
    int   obs_loads, obs_computes, obs_clears, obs_beats;

    // {state, phase, m, n, wl, is, clr, fl, dr, done, idle, err}
    function automatic logic [58:0] pack_exp(logic [2:0] st, int ph, int m, int n, bit err);
        return {st, W'(ph), W'(m), W'(n),
                st == 3'd1, st == 3'd2, (st == 3'd2) && (ph == 0), st == 3'd3,
                st == 3'd4, st == 3'd5, st == 3'd0, err};
    endfunction

    function automatic logic [58:0] pack_obs();
        return {state_dbg, phase_cnt, tile_m_idx, tile_n_idx,
                ctrl_weight_load_en, ctrl_input_stream_en, ctrl_acc_clear,
                ctrl_flush_en, ctrl_drain_en, ap_done, ap_idle, cfg_err};
    endfunction

    function automatic void push_rec(logic [2:0] st, int ph, int m, int n, bit rdy);
        rec_t r;
        r.st = st; r.ph = ph; r.m = m; r.n = n; r.rdy = rdy;
        exp_q.push_back(r);
    endfunction

    // Expected per-cycle schedule of a whole job.
    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random.
    function automatic void build_model(int k, int mt, int nt, int mode);
        exp_q.delete();
        for (int n = 0; n < nt; n++) begin
            for (int m = 0; m < mt; m++) begin
                if (m == 0)
                    for (int i = 0; i < ROW; i++) push_rec(3'd1, i, m, n, 1'b0);
                for (int i = 0; i < k; i++)  push_rec(3'd2, i, m, n, 1'b0);
                for (int i = 0; i < PL; i++) push_rec(3'd3, i, m, n, 1'b0);
                begin
                    int beats = 0;
                    int dcyc  = 0;
                    while (beats < COL) begin
                        bit r;
                        case (mode)
                            0:       r = 1'b1;
                            1:       r = ((dcyc % 3) == 0);
                            default: r = 1'($urandom_range(0, 1));
                        endcase
                        push_rec(3'd4, beats, m, n, r);
                        if (r) beats++;
                        dcyc++;
                    end
                end
            end
        end
    endfunction

    // Runs one job against the model; optional abort at model cycle abort_at
    task automatic run_job(input int k, input int mt, input int nt, input int mode,
                           input int abort_at, input bit hold_start);
        logic [58:0] obs, expv;
        build_model(k, mt, nt, mode);
        obs_loads = 0; obs_computes = 0; obs_clears = 0; obs_beats = 0;
        visit_q.delete();
        cfg_k_dim = W'(k); cfg_m_tiles = W'(mt); cfg_n_tiles = W'(nt);
        drain_ready = 1'b0;
        ap_start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) ap_start = 1'b0;
        cfg_k_dim = W'($urandom); cfg_m_tiles = W'($urandom); cfg_n_tiles = W'($urandom);
        for (int t = 0; t < exp_q.size(); t++) begin
            rec_t r;
            r = exp_q[t];
            drain_ready = r.rdy;
            obs  = pack_obs();
            expv = pack_exp(r.st, r.ph, r.m, r.n, 1'b0);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL job_cycle %0d: got %h expected %h", t, obs, expv);
            end
            if (ctrl_weight_load_en && phase_cnt == 0) obs_loads++;
            if (state_dbg == 3'd2 && phase_cnt == 0) begin
                obs_computes++;
                visit_q.push_back(int'(tile_n_idx) * 16 + int'(tile_m_idx));
            end
            if (ctrl_acc_clear) obs_clears++;
            if (ctrl_drain_en && drain_ready) obs_beats++;
            if (t == abort_at) begin
                ap_abort = 1'b1;
                @(posedge clk); #1;
                ap_abort = 1'b0;
                drain_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    obs  = pack_obs();
                    expv = pack_exp(3'd0, 0, int'(tile_m_idx), int'(tile_n_idx), 1'b0);
                    n_checks++;
                    if (obs !== expv) begin
                        n_fail++;
                        $display("FAIL abort_idle cyc %0d: got %h expected %h", j, obs, expv);
                    end
                    @(posedge clk); #1;
                end
                return;
            end
            @(posedge clk); #1;
        end
        drain_ready = 1'b0;
        obs  = pack_obs();
        expv = pack_exp(3'd5, 0, mt - 1, nt - 1, 1'b0);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL job_done: got %h expected %h", obs, expv);
        end
        if (hold_start) begin
            for (int j = 0; j < 3; j++) begin
                @(posedge clk); #1;
                n_checks++;
                if (state_dbg !== 3'd5 || ap_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_hold cyc %0d: state %0d done %b expected 5 1", j, state_dbg, ap_done);
                end
            end
            ap_start = 1'b0;
        end
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if (state_dbg !== 3'd0 || ap_idle !== 1'b1 || ap_done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_to_idle cyc %0d: state %0d idle %b done %b expected 0 1 0",
                         j, state_dbg, ap_idle, ap_done);
            end
        end
    endtask

    task automatic test_reset();
        logic [58:0] expv;
        rst_n = 1'b0; ap_start = 1'b0; ap_abort = 1'b0; drain_ready = 1'b0;
        cfg_k_dim = '0; cfg_m_tiles = '0; cfg_n_tiles = '0;
        repeat (2) @(posedge clk);
        #1;
        expv = pack_exp(3'd0, 0, 0, 0, 1'b0);
        n_checks++;
        if (pack_obs() !== expv) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", pack_obs(), expv);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        run_job(4, 1, 1, 0, -1, 1'b1);
        n_checks++;
        if (obs_beats != COL) begin
            n_fail++;
            $display("FAIL single_beats: got %0d expected %0d", obs_beats, COL);
        end
    endtask

    task automatic test_multi_tile();
        int exp_visits[4] = '{0, 1, 16, 17};
        run_job(3, 2, 2, 0, -1, 1'b0);
        n_checks++;
        if (obs_loads != 2 || obs_computes != 4 || obs_clears != 4) begin
            n_fail++;
            $display("FAIL multi_counts: loads %0d computes %0d clears %0d expected 2 4 4",
                     obs_loads, obs_computes, obs_clears);
        end
        n_checks++;
        if (visit_q.size() != 4) begin
            n_fail++;
            $display("FAIL multi_visit_len: got %0d expected 4", visit_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (visit_q[i] != exp_visits[i]) begin
                    n_fail++;
                    $display("FAIL multi_visit %0d: got n*16+m=%0d expected %0d", i, visit_q[i], exp_visits[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        run_job(2, 1, 1, 1, -1, 1'b0);
        n_checks++;
        if (obs_beats != COL) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d expected %0d", obs_beats, COL);
        end
    endtask

    task automatic test_random_jobs();
        for (int i = 0; i < 4; i++) begin
            run_job($urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(1, 3), 2, -1, 1'b0);
            n_checks++;
            if (obs_clears != obs_computes) begin
                n_fail++;
                $display("FAIL rand_clears job %0d: clears %0d computes %0d", i, obs_clears, obs_computes);
            end
        end
    endtask

    task automatic test_cfg_err();
        logic [58:0] expv;
        for (int c = 0; c < 2; c++) begin
            cfg_k_dim   = (c == 0) ? W'(0) : W'(5);
            cfg_m_tiles = (c == 0) ? W'(2) : W'(0);
            cfg_n_tiles = W'(2);
            ap_start = 1'b1;
            @(posedge clk); #1;
            ap_start = 1'b0;
            expv = pack_exp(3'd5, 0, 0, 0, 1'b1);
            n_checks++;
            if (pack_obs() !== expv) begin
                n_fail++;
                $display("FAIL cfg_err_done case %0d: got %h expected %h", c, pack_obs(), expv);
            end
            @(posedge clk); #1;
            expv = pack_exp(3'd0, 0, 0, 0, 1'b1);
            n_checks++;
            if (pack_obs() !== expv) begin
                n_fail++;
                $display("FAIL cfg_err_idle case %0d: got %h expected %h", c, pack_obs(), expv);
            end
        end
        // The next valid job must see cfg_err cleared from its first cycle
        run_job(2, 1, 1, 0, -1, 1'b0);
    endtask

    task automatic test_abort();
        // Abort in the middle of FLUSH
        run_job(3, 1, 1, 0, ROW + 3 + 5, 1'b0);
        // Abort on the final accepted drain beat
        run_job(2, 1, 1, 0, ROW + 2 + PL + COL - 1, 1'b0);
        // Abort while IDLE is ignored: start still accepted
        cfg_k_dim = W'(2); cfg_m_tiles = W'(1); cfg_n_tiles = W'(1);
        ap_start = 1'b1; ap_abort = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0; ap_abort = 1'b0;
        n_checks++;
        if (state_dbg !== 3'd1 || ctrl_weight_load_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_idle: state %0d wl %b expected 1 1", state_dbg, ctrl_weight_load_en);
        end
        ap_abort = 1'b1;
        @(posedge clk); #1;
        ap_abort = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_job();
        logic [58:0] expv;
        cfg_k_dim = W'(6); cfg_m_tiles = W'(2); cfg_n_tiles = W'(2);
        ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
        repeat (ROW + 2) @(posedge clk);
        #1;
        expv = pack_exp(3'd2, 2, 0, 0, 1'b0);
        n_checks++;
        if (pack_obs() !== expv) begin
            n_fail++;
            $display("FAIL pre_reset_compute: got %h expected %h", pack_obs(), expv);
        end
        rst_n = 1'b0; ap_start = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        expv = pack_exp(3'd0, 0, 0, 0, 1'b0);
        n_checks++;
        if (pack_obs() !== expv) begin
            n_fail++;
            $display("FAIL mid_reset_values: got %h expected %h", pack_obs(), expv);
        end
        @(posedge clk); #1;
        ap_start = 1'b0;
        expv = pack_exp(3'd1, 0, 0, 0, 1'b0);
        n_checks++;
        if (pack_obs() !== expv) begin
            n_fail++;
            $display("FAIL restart_after_reset: got %h expected %h", pack_obs(), expv);
        end
        ap_abort = 1'b1;
        @(posedge clk); #1;
        ap_abort = 1'b0;
        n_checks++;
        if (state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset_abort: state %0d expected 0", state_dbg);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_tile();
        test_backpressure();
        test_random_jobs();
        test_cfg_err();
        test_abort();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
